// File: rtl/s1_state_timer.sv
// Input conditioning, state register and in-state timer around the s1 next-state logic.
// Sensors are synchronized and debounced; T flags a dwell of TIMEOUT ticks in one state.
module s1_state_timer #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned PRESC      = 1000,
    parameter int unsigned TIMER_W    = 16,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               h_raw,
    input  logic               m_raw,
    input  logic               l_raw,
    input  logic               us_raw,
    input  logic               ua_raw,
    input  logic               dff0,
    input  logic               dff1,
    output logic               h,
    output logic               m,
    output logic               l,
    output logic               us,
    output logic               ua,
    output logic               ff0,
    output logic               ff1,
    output logic               t,
    output logic [TIMER_W-1:0] tcnt,
    output logic               err
);

    localparam int unsigned NS = 5;
    localparam int unsigned DW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [DW-1:0]      DEB_LAST = DW'(DEB_CYCLES);
    localparam logic [PW-1:0]      PRE_LAST = PW'(PRESC - 1);
    localparam logic [TIMER_W-1:0] TMO      = TIMER_W'(TIMEOUT);

    // Sensor order: {h, m, l, us, ua}
    logic [NS-1:0] raw;
    logic [NS-1:0] sync1_q;
    logic [NS-1:0] sync2_q;
    logic [NS-1:0] clean_q;
    logic [NS-1:0] clean_nxt;
    logic [DW-1:0] deb_q   [NS];
    logic [DW-1:0] deb_nxt [NS];

    logic [1:0]         st_q;
    logic [PW-1:0]      pre_q;
    logic [PW-1:0]      pre_nxt;
    logic [TIMER_W-1:0] tcnt_q;
    logic [TIMER_W-1:0] tcnt_nxt;
    logic               t_q;
    logic               err_q;
    logic               tick_c;
    logic               chg_c;

    assign raw = {h_raw, m_raw, l_raw, us_raw, ua_raw};

    // Two-flop synchronizer for the asynchronous sensors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a mismatch must persist past DEB_CYCLES counts before the clean value follows
    always_comb begin
        clean_nxt = clean_q;
        for (int i = 0; i < NS; i++) begin
            deb_nxt[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    clean_nxt[i] = sync2_q[i];
                end else begin
                    deb_nxt[i] = deb_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q <= '0;
            for (int i = 0; i < NS; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            clean_q <= clean_nxt;
            for (int i = 0; i < NS; i++) begin
                deb_q[i] <= deb_nxt[i];
            end
        end
    end

    // Level consistency: a higher sensor wet while a lower one is dry is impossible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (clean_q[4] & ~clean_q[3]) | (clean_q[4] & ~clean_q[2]) |
                     (clean_q[3] & ~clean_q[2]);
        end
    end

    // Prescaler tick and state-change detection
    always_comb begin
        tick_c  = en && (pre_q == PRE_LAST);
        chg_c   = en && ({dff1, dff0} != st_q);
        pre_nxt = pre_q;
        if (en) begin
            pre_nxt = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    // In-state tick counter: a state change wins over a coincident tick; saturates at TIMEOUT
    always_comb begin
        tcnt_nxt = tcnt_q;
        if (chg_c) begin
            tcnt_nxt = '0;
        end else if (tick_c && (tcnt_q < TMO)) begin
            tcnt_nxt = tcnt_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= 2'b00;
            pre_q  <= '0;
            tcnt_q <= '0;
            t_q    <= 1'b0;
        end else begin
            tcnt_q <= tcnt_nxt;
            if (en) begin
                st_q  <= {dff1, dff0};
                pre_q <= pre_nxt;
                t_q   <= (tcnt_nxt >= TMO);
            end
        end
    end

    assign h    = clean_q[4];
    assign m    = clean_q[3];
    assign l    = clean_q[2];
    assign us   = clean_q[1];
    assign ua   = clean_q[0];
    assign ff1  = st_q[1];
    assign ff0  = st_q[0];
    assign t    = t_q;
    assign tcnt = tcnt_q;
    assign err  = err_q;

endmodule

// File: tb/tb_s1_state_timer.sv
// Bench for s1_state_timer: windowed debounce model, tick-count timer model, directed pins and random traffic.
module tb_s1_state_timer;

    localparam int unsigned DEB   = 3;
    localparam int unsigned PRESC = 2;
    localparam int unsigned TW    = 4;
    localparam int unsigned TMO   = 3;
    localparam logic [4:0]  ALL   = 5'b11111;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          h_raw, m_raw, l_raw, us_raw, ua_raw;
    logic          dff0, dff1;
    logic          h, m, l, us, ua;
    logic          ff0, ff1;
    logic          t;
    logic [TW-1:0] tcnt;
    logic          err;

    int checks = 0;
    int errors = 0;

    s1_state_timer #(
        .DEB_CYCLES(DEB),
        .PRESC     (PRESC),
        .TIMER_W   (TW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .h_raw (h_raw),
        .m_raw (m_raw),
        .l_raw (l_raw),
        .us_raw(us_raw),
        .ua_raw(ua_raw),
        .dff0  (dff0),
        .dff1  (dff1),
        .h     (h),
        .m     (m),
        .l     (l),
        .us    (us),
        .ua    (ua),
        .ff0   (ff0),
        .ff1   (ff1),
        .t     (t),
        .tcnt  (tcnt),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: raw-sample history window for debounce, tick counting for the timer
    logic [4:0] hist [0:DEB+2];
    logic [4:0] m_clean;
    logic       m_err;
    logic [1:0] m_ff;
    logic       m_t;
    int         m_tcnt;
    int         m_ticks;
    int         en_edges;
    bit         m_tick, m_chg, m_stable;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DEB + 2; k++) hist[k] = '0;
            m_clean  = '0;
            m_err    = 1'b0;
            m_ff     = 2'b00;
            m_t      = 1'b0;
            m_tcnt   = 0;
            m_ticks  = 0;
            en_edges = 0;
        end else begin
            m_err = (m_clean[4] && !m_clean[3]) || (m_clean[4] && !m_clean[2]) ||
                    (m_clean[3] && !m_clean[2]);
            for (int k = DEB + 2; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {h_raw, m_raw, l_raw, us_raw, ua_raw};
            // hist[2] is what the synchronizer presents now; DEB+1 equal samples move the clean value
            for (int b = 0; b < 5; b++) begin
                m_stable = 1'b1;
                for (int k = 3; k <= DEB + 2; k++)
                    if (hist[k][b] != hist[2][b]) m_stable = 1'b0;
                if (m_stable && (hist[2][b] != m_clean[b])) m_clean[b] = hist[2][b];
            end
            m_tick = en && ((en_edges % PRESC) == (PRESC - 1));
            m_chg  = en && ({dff1, dff0} != m_ff);
            if (m_chg) m_ticks = 0;
            else if (m_tick) m_ticks++;
            m_tcnt = (m_ticks < TMO) ? m_ticks : TMO;
            if (en) begin
                m_t  = (m_tcnt >= TMO);
                m_ff = {dff1, dff0};
                en_edges++;
            end
        end
    end

    // Literal expectations posted by the stimulus, consumed at the next falling edge
    string      lit_name;
    logic [4:0] lit_mask;
    logic [1:0] lit_ff;
    int         lit_tcnt;
    logic       lit_t;
    logic [4:0] lit_sens;
    logic       lit_err;
    int         lit_seq  = 0;
    int         lit_seen = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("ff",   int'({ff1, ff0}), int'(m_ff));
        cmp("tcnt", int'(tcnt), m_tcnt);
        cmp("t",    int'(t), int'(m_t));
        cmp("sens", int'({h, m, l, us, ua}), int'(m_clean));
        cmp("err",  int'(err), int'(m_err));
        if (lit_seq != lit_seen) begin
            if (lit_mask[0]) cmp({lit_name, ".ff"},   int'({ff1, ff0}), int'(lit_ff));
            if (lit_mask[1]) cmp({lit_name, ".tcnt"}, int'(tcnt), lit_tcnt);
            if (lit_mask[2]) cmp({lit_name, ".t"},    int'(t), int'(lit_t));
            if (lit_mask[3]) cmp({lit_name, ".sens"}, int'({h, m, l, us, ua}), int'(lit_sens));
            if (lit_mask[4]) cmp({lit_name, ".err"},  int'(err), int'(lit_err));
            lit_seen = lit_seq;
        end
    end

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string nm, input logic [4:0] mask, input logic [1:0] f,
                       input int tc, input logic tt, input logic [4:0] sn, input logic er);
        lit_name = nm;
        lit_mask = mask;
        lit_ff   = f;
        lit_tcnt = tc;
        lit_t    = tt;
        lit_sens = sn;
        lit_err  = er;
        lit_seq++;
    endtask

    task automatic pst(input string nm, input logic [1:0] f, input int tc, input logic tt);
        pin(nm, ALL, f, tc, tt, 5'b11100, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0;
        h_raw = 1'b0; m_raw = 1'b0; l_raw = 1'b0; us_raw = 1'b0; ua_raw = 1'b0;
        dff0 = 1'b0; dff1 = 1'b0;
        repeat (3) adv();
        pin("reset_state", ALL, 2'b00, 0, 1'b0, 5'b00000, 1'b0);
        rst_n = 1'b1;

        // Two-cycle glitch on L never reaches the clean output
        l_raw = 1'b1;
        adv(); adv();
        l_raw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            adv();
            pin("glitch", ALL, 2'b00, 0, 1'b0, 5'b00000, 1'b0);
        end

        // Held rise appears exactly five edges after the first sampling edge; fall likewise
        l_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adv();
            pin("rise_wait", ALL, 2'b00, 0, 1'b0, 5'b00000, 1'b0);
        end
        adv(); pin("rise", ALL, 2'b00, 0, 1'b0, 5'b00100, 1'b0);
        l_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            adv();
            pin("fall_wait", ALL, 2'b00, 0, 1'b0, 5'b00100, 1'b0);
        end
        adv(); pin("fall", ALL, 2'b00, 0, 1'b0, 5'b00000, 1'b0);

        // ERR follows the clean levels one cycle late
        h_raw = 1'b1; l_raw = 1'b1;
        repeat (5) adv();
        adv(); pin("hl_settle", ALL, 2'b00, 0, 1'b0, 5'b10100, 1'b0);
        adv(); pin("err_set",   ALL, 2'b00, 0, 1'b0, 5'b10100, 1'b1);
        m_raw = 1'b1;
        repeat (5) adv();
        adv(); pin("m_rise",  ALL, 2'b00, 0, 1'b0, 5'b11100, 1'b1);
        adv(); pin("err_clr", ALL, 2'b00, 0, 1'b0, 5'b11100, 1'b0);

        // State load, tick every second edge, saturation at TIMEOUT
        en = 1'b1; {dff1, dff0} = 2'b01;
        adv(); pst("load", 2'b01, 0, 1'b0);
        adv(); pst("tick1", 2'b01, 1, 1'b0);
        adv(); pst("hold1", 2'b01, 1, 1'b0);
        adv(); pst("tick2", 2'b01, 2, 1'b0);
        adv(); pst("hold2", 2'b01, 2, 1'b0);
        adv(); pst("timeout", 2'b01, 3, 1'b1);
        adv(); pst("sat_a", 2'b01, 3, 1'b1);
        adv(); pst("sat_b", 2'b01, 3, 1'b1);

        // State change clears the timer and T, and beats a coincident tick
        {dff1, dff0} = 2'b10;
        adv(); pst("chg_10", 2'b10, 0, 1'b0);
        adv(); adv(); adv();
        adv(); pst("pre_chg", 2'b10, 2, 1'b0);
        {dff1, dff0} = 2'b11;
        adv(); pst("chg_on_tick", 2'b11, 0, 1'b0);
        adv(); adv(); pst("tick_11", 2'b11, 1, 1'b0);

        // Freeze: state, prescaler and timer hold while DFF wanders; sensors keep running
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            {dff1, dff0} = 2'($urandom_range(0, 3));
            adv();
            pst("freeze", 2'b11, 1, 1'b0);
        end
        en = 1'b1; {dff1, dff0} = 2'b11;
        adv(); pst("thaw_no_tick", 2'b11, 1, 1'b0);
        adv(); pst("thaw_tick", 2'b11, 2, 1'b0);

        // Reach T=1 in state 01, then reset asynchronously between clock edges
        {dff1, dff0} = 2'b01;
        repeat (6) adv();
        adv(); pst("pre_reset", 2'b01, 3, 1'b1);
        adv();
        #1;
        rst_n = 1'b0;
        pin("async_reset", ALL, 2'b00, 0, 1'b0, 5'b00000, 1'b0);
        adv(); adv();
        rst_n = 1'b1;

        // Random traffic with one mid-run reset
        for (int c = 0; c < 600; c++) begin
            adv();
            if ($urandom_range(0, 5) == 0) h_raw  = ~h_raw;
            if ($urandom_range(0, 5) == 0) m_raw  = ~m_raw;
            if ($urandom_range(0, 5) == 0) l_raw  = ~l_raw;
            if ($urandom_range(0, 4) == 0) us_raw = ~us_raw;
            if ($urandom_range(0, 3) == 0) ua_raw = ~ua_raw;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) {dff1, dff0} = 2'($urandom_range(0, 3));
            if (c == 300) begin
                #1;
                rst_n = 1'b0;
            end
            if (c == 302) rst_n = 1'b1;
        end

        adv(); adv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
